riot_multi: RTL and testbench

Parametrised RIOT-class peripheral (RAM, two bidirectional I/O ports, a bank of interval timers, PA edge detector) for the 7800/2600 cores. It is the next generation of the single-timer 6532 model. Generalisations: configurable port width, timer count and RAM depth; per-timer auto-reload mode; write-1-to-clear interrupt flags. It sits on the CPU bus beside TIA/MARIA and is clocked by the CPU phase enable.

---
 rtl/riot_multi.sv | 186 ++++++++++++++++++
 tb/tb_riot_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riot_multi.sv
// riot_multi: RAM, two bidirectional ports, NUM_TIMERS interval timers and a PA edge detector, all advanced by ce.
// Reads are registered with 1 enabled-cycle latency; there is no backpressure. Define RIOT_RAM_EN to include RAM storage.
module riot_multi #(
    parameter int PORT_W     = 8,
    parameter int NUM_TIMERS = 2,
    parameter int RAM_AW     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [7:0]        addr,
    input  logic              rw_n,
    input  logic              cs,
    input  logic              rs_n,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              irq_n,
    input  logic [PORT_W-1:0] pa_in,
    input  logic [PORT_W-1:0] pb_in,
    output logic [PORT_W-1:0] pa_out,
    output logic [PORT_W-1:0] pb_out,
    output logic [PORT_W-1:0] pa_dir,
    output logic [PORT_W-1:0] pb_dir
);
    logic [7:0]            t_count  [NUM_TIMERS];
    logic [7:0]            t_reload [NUM_TIMERS];
    logic [1:0]            t_ps     [NUM_TIMERS];
    logic [9:0]            t_pre    [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] t_ien, t_mode, t_run, t_fast, t_flag, tick;
    logic                  edge_pol, edge_en, edge_flag, pa7_q;
    logic [PORT_W-1:0]     pa_rd, pb_rd;
    logic                  pa7, edge_hit, rd, wr, reg_wr, ifr_wr, tmr_sel;
    logic [1:0]            tidx;
    logic [7:0]            rdata, ram_rd;
    logic [3:0]            tflag4;

    function automatic logic [9:0] div_lim(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10'd0;
            2'd1:    return 10'd7;
            2'd2:    return 10'd63;
            default: return 10'd1023;
        endcase
    endfunction

    assign rd       = ce & cs & rw_n;
    assign wr       = ce & cs & ~rw_n;
    assign reg_wr   = wr & rs_n;
    assign ifr_wr   = reg_wr & (addr == 8'h05);
    assign tmr_sel  = (addr[7:4] == 4'h1);
    assign tidx     = addr[3:2];
    assign pa_rd    = (pa_out & pa_dir) | (pa_in & ~pa_dir);
    assign pb_rd    = (pb_out & pb_dir) | (pb_in & ~pb_dir);
    assign pa7      = pa_rd[PORT_W-1];
    assign edge_hit = edge_pol ? (~pa7_q & pa7) : (pa7_q & ~pa7);
    assign tflag4   = 4'(t_flag);
    assign irq_n    = ~(|(t_flag & t_ien) | (edge_flag & edge_en));

`ifdef RIOT_RAM_EN
    logic [7:0] ram [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (!reset && wr && !rs_n)
            ram[addr[RAM_AW-1:0]] <= d_in;
    end
    assign ram_rd = ram[addr[RAM_AW-1:0]];
`else
    assign ram_rd = 8'hFF;
`endif

    // A timer in legacy fast state ticks on every enabled cycle regardless of prescale select.
    always_comb begin
        tick = '0;
        for (int n = 0; n < NUM_TIMERS; n++)
            tick[n] = t_run[n] & (t_pre[n] == (t_fast[n] ? 10'd0 : div_lim(t_ps[n])));
    end

    always_comb begin
        rdata = 8'h00;
        if (!rs_n) begin
            rdata = ram_rd;
        end else if (tmr_sel) begin
            for (int n = 0; n < NUM_TIMERS; n++) begin
                if (tidx == 2'(n)) begin
                    if (addr[1:0] == 2'd0)
                        rdata = t_count[n];
                    else if (addr[1:0] == 2'd1)
                        rdata = {3'b000, t_run[n], t_mode[n], t_ien[n], t_ps[n]};
                end
            end
        end else begin
            case (addr)
                8'h00:   rdata = 8'(pa_rd);
                8'h01:   rdata = 8'(pa_dir);
                8'h02:   rdata = 8'(pb_rd);
                8'h03:   rdata = 8'(pb_dir);
                8'h04:   rdata = {6'b000000, edge_en, edge_pol};
                8'h05:   rdata = {edge_flag, 3'b000, tflag4};
                default: rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_out     <= 8'hFF;
            pa_out    <= '0;
            pa_dir    <= '0;
            pb_out    <= '0;
            pb_dir    <= '0;
            edge_pol  <= 1'b0;
            edge_en   <= 1'b0;
            edge_flag <= 1'b0;
            pa7_q     <= 1'b0;
            t_ien     <= '0;
            t_mode    <= '0;
            t_run     <= '1;
            t_fast    <= '0;
            t_flag    <= '0;
            for (int n = 0; n < NUM_TIMERS; n++) begin
                t_count[n]  <= 8'hFF;
                t_reload[n] <= 8'hFF;
                t_ps[n]     <= 2'd2;
                t_pre[n]    <= '0;
            end
        end else if (ce) begin
            if (rd)
                d_out <= rdata;

            pa7_q <= pa7;
            if (edge_hit)
                edge_flag <= 1'b1;
            else if (ifr_wr && d_in[7])
                edge_flag <= 1'b0;

            if (reg_wr) begin
                case (addr)
                    8'h00: pa_out <= d_in[PORT_W-1:0];
                    8'h01: pa_dir <= d_in[PORT_W-1:0];
                    8'h02: pb_out <= d_in[PORT_W-1:0];
                    8'h03: pb_dir <= d_in[PORT_W-1:0];
                    8'h04: begin
                        edge_pol <= d_in[0];
                        edge_en  <= d_in[1];
                    end
                    default: ;
                endcase
            end

            // Register writes come last so a COUNT write overrides a same-cycle tick.
            for (int n = 0; n < NUM_TIMERS; n++) begin
                t_pre[n] <= tick[n] ? 10'd0 : t_pre[n] + 10'd1;
                if (tick[n]) begin
                    if (t_count[n] != 8'h00) begin
                        t_count[n] <= t_count[n] - 8'h01;
                    end else if (t_mode[n]) begin
                        t_count[n] <= t_reload[n];
                    end else begin
                        t_count[n] <= 8'hFF;
                        t_fast[n]  <= 1'b1;
                    end
                end

                if (tick[n] && t_count[n] == 8'h00)
                    t_flag[n] <= 1'b1;
                else if (ifr_wr && d_in[n])
                    t_flag[n] <= 1'b0;

                if (reg_wr && tmr_sel && tidx == 2'(n) && addr[1:0] == 2'd0) begin
                    t_count[n]  <= d_in;
                    t_reload[n] <= d_in;
                    t_pre[n]    <= '0;
                    t_flag[n]   <= 1'b0;
                    t_run[n]    <= 1'b1;
                    t_fast[n]   <= 1'b0;
                end else if (reg_wr && tmr_sel && tidx == 2'(n) && addr[1:0] == 2'd1) begin
                    t_ps[n]   <= d_in[1:0];
                    t_ien[n]  <= d_in[2];
                    t_mode[n] <= d_in[3];
                    t_run[n]  <= d_in[4];
                    t_fast[n] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_riot_multi.sv
// Directed and randomized bench for riot_multi against a behavioural model kept in the bench.
module tb_riot_multi;
    localparam int NT = 2;
    localparam int PW = 8;
    localparam int AW = 7;
`ifdef RIOT_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1, ce = 1'b0, rw_n = 1'b1, cs = 1'b0, rs_n = 1'b1;
    logic [7:0]    addr = 8'h00, d_in = 8'h00, d_out;
    logic          irq_n;
    logic [PW-1:0] pa_in = '0, pb_in = '0, pa_out, pb_out, pa_dir, pb_dir;

    riot_multi #(.PORT_W(PW), .NUM_TIMERS(NT), .RAM_AW(AW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .addr(addr), .rw_n(rw_n), .cs(cs), .rs_n(rs_n),
        .d_in(d_in), .d_out(d_out), .irq_n(irq_n), .pa_in(pa_in), .pb_in(pb_in),
        .pa_out(pa_out), .pb_out(pb_out), .pa_dir(pa_dir), .pb_dir(pb_dir)
    );

    always #5 clk = ~clk;

    int npass = 0, ntot = 0;
    int divs [4] = '{1, 8, 64, 1024};

    logic [7:0]    m_dout;
    logic [PW-1:0] m_pao, m_pad, m_pbo, m_pbd;
    bit            m_pol, m_een, m_ef, m_prev;
    int            m_cnt [4], m_rel [4], m_ps [4], m_pre [4];
    bit            m_ien [4], m_mode [4], m_run [4], m_fast [4], m_tf [4];
    logic [7:0]    m_ram [256];

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_dout = 8'hFF; m_pao = '0; m_pad = '0; m_pbo = '0; m_pbd = '0;
        m_pol = 0; m_een = 0; m_ef = 0; m_prev = 0;
        for (int n = 0; n < 4; n++) begin
            m_cnt[n] = 255; m_rel[n] = 255; m_ps[n] = 2; m_pre[n] = 0;
            m_ien[n] = 0; m_mode[n] = 0; m_run[n] = 1; m_fast[n] = 0; m_tf[n] = 0;
        end
    endtask

    function automatic logic [PW-1:0] pa_view();
        return (m_pao & m_pad) | (pa_in & ~m_pad);
    endfunction

    function automatic logic [7:0] model_read(input int a, input bit rs);
        int n;
        int v;
        if (!rs) return RAM_EN ? m_ram[a % (1 << AW)] : 8'hFF;
        if (a >= 16 && a < 32) begin
            n = (a - 16) / 4;
            if (n >= NT) return 8'h00;
            if (a % 4 == 0) return 8'(m_cnt[n]);
            if (a % 4 == 1) return 8'(m_ps[n] + 4 * m_ien[n] + 8 * m_mode[n] + 16 * m_run[n]);
            return 8'h00;
        end
        case (a)
            0: return 8'(pa_view());
            1: return 8'(m_pad);
            2: return 8'((m_pbo & m_pbd) | (pb_in & ~m_pbd));
            3: return 8'(m_pbd);
            4: return 8'(2 * m_een + m_pol);
            5: begin
                v = 128 * m_ef;
                for (int k = 0; k < NT; k++) v += m_tf[k] << k;
                return 8'(v);
            end
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic model_irq_n();
        bit any = m_ef && m_een;
        for (int n = 0; n < NT; n++) any |= m_tf[n] && m_ien[n];
        return !any;
    endfunction

    task automatic model_edge();
        bit setf [4];
        bit eset, pa7;
        int lim, a, n;
        if (reset) begin model_reset(); return; end
        if (!ce) return;
        a = int'(addr);
        if (cs && rw_n) m_dout = model_read(a, rs_n);
        for (int k = 0; k < NT; k++) begin
            setf[k] = 0;
            lim = m_fast[k] ? 1 : divs[m_ps[k]];
            if (m_run[k] && m_pre[k] == lim - 1) begin
                m_pre[k] = 0;
                if (m_cnt[k] > 0) m_cnt[k]--;
                else begin
                    setf[k] = 1;
                    if (m_mode[k]) m_cnt[k] = m_rel[k];
                    else begin m_cnt[k] = 255; m_fast[k] = 1; end
                end
            end else m_pre[k] = (m_pre[k] + 1) % 1024;
        end
        pa7 = pa_view()[PW-1];
        eset = m_pol ? (!m_prev && pa7) : (m_prev && !pa7);
        m_prev = pa7;
        if (cs && !rw_n) begin
            if (!rs_n) begin
                if (RAM_EN) m_ram[a % (1 << AW)] = d_in;
            end else if (a >= 16 && a < 32) begin
                n = (a - 16) / 4;
                if (n < NT && a % 4 == 0) begin
                    m_cnt[n] = d_in; m_rel[n] = d_in; m_pre[n] = 0; m_tf[n] = 0;
                    setf[n] = 0; m_run[n] = 1; m_fast[n] = 0;
                end else if (n < NT && a % 4 == 1) begin
                    m_ps[n] = d_in % 4; m_ien[n] = d_in[2]; m_mode[n] = d_in[3];
                    m_run[n] = d_in[4]; m_fast[n] = 0;
                end
            end else begin
                case (a)
                    0: m_pao = d_in[PW-1:0];
                    1: m_pad = d_in[PW-1:0];
                    2: m_pbo = d_in[PW-1:0];
                    3: m_pbd = d_in[PW-1:0];
                    4: begin m_pol = d_in[0]; m_een = d_in[1]; end
                    5: begin
                        for (int k = 0; k < NT; k++) if (d_in[k]) m_tf[k] = 0;
                        if (d_in[7]) m_ef = 0;
                    end
                    default: ;
                endcase
            end
        end
        for (int k = 0; k < NT; k++) if (setf[k]) m_tf[k] = 1;
        if (eset) m_ef = 1;
    endtask

    task automatic step(input bit ce_i, input bit cs_i, input bit rw_i, input bit rs_i,
                        input logic [7:0] a, input logic [7:0] d);
        ce = ce_i; cs = cs_i; rw_n = rw_i; rs_n = rs_i; addr = a; d_in = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("d_out", d_out, m_dout);
        chk("irq_n", 8'(irq_n), 8'(model_irq_n()));
        chk("pa_out", 8'(pa_out), 8'(m_pao));
        chk("pa_dir", 8'(pa_dir), 8'(m_pad));
        chk("pb_out", 8'(pb_out), 8'(m_pbo));
        chk("pb_dir", 8'(pb_dir), 8'(m_pbd));
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        step(1, 1, 0, 1, a, d);
    endtask

    task automatic rd_reg(input logic [7:0] a);
        step(1, 1, 1, 1, a, 8'h00);
    endtask

    task automatic nop();
        step(1, 0, 1, 1, 8'h00, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_ram[i] = 8'h00;
        model_reset();
        #1;
        reset = 1;
        step(0, 0, 1, 1, 8'h00, 8'h00);
        step(1, 1, 1, 1, 8'h10, 8'h00);
        reset = 0;
        chk("rst_dout", d_out, 8'hFF);
        chk("rst_irq", 8'(irq_n), 8'h01);

        rd_reg(8'h10);
        chk("rst_count0", d_out, 8'hFF);
        rd_reg(8'h11);
        chk("rst_ctrl0", d_out, 8'h12);

        // Timer 0: /1, legacy, IRQ enabled, loaded with 3.
        wr_reg(8'h11, 8'h04);
        wr_reg(8'h10, 8'h03);
        rd_reg(8'h10);
        chk("t0_cnt3", d_out, 8'h03);
        rd_reg(8'h10);
        chk("t0_cnt2", d_out, 8'h02);
        rd_reg(8'h10);
        chk("t0_cnt1", d_out, 8'h01);
        rd_reg(8'h10);
        chk("t0_cnt0", d_out, 8'h00);
        chk("t0_irq", 8'(irq_n), 8'h00);
        rd_reg(8'h10);
        chk("t0_fast_ff", d_out, 8'hFF);
        rd_reg(8'h10);
        chk("t0_fast_fe", d_out, 8'hFE);
        wr_reg(8'h11, 8'h00);
        wr_reg(8'h05, 8'h01);
        chk("t0_irq_clr", 8'(irq_n), 8'h01);

        // Timer 1: /8 auto-reload from 2, flag after 24 enabled cycles.
        wr_reg(8'h15, 8'h09);
        wr_reg(8'h14, 8'h02);
        for (int i = 0; i < 23; i++) nop();
        rd_reg(8'h05);
        chk("t1_noflag", d_out, 8'h00);
        rd_reg(8'h05);
        chk("t1_flag", d_out, 8'h02);
        rd_reg(8'h14);
        chk("t1_reload", d_out, 8'h02);
        wr_reg(8'h05, 8'h02);
        rd_reg(8'h05);
        chk("t1_clr", d_out, 8'h00);
        wr_reg(8'h15, 8'h00);

        // Port A mix of output latch and input pins.
        wr_reg(8'h01, 8'h0F);
        wr_reg(8'h00, 8'hAA);
        pa_in = 8'h50;
        rd_reg(8'h00);
        chk("pa_mix", d_out, 8'h5A);

        // Edge detector, rising, enabled.
        wr_reg(8'h04, 8'h03);
        pa_in = 8'hD0;
        nop();
        chk("edge_irq", 8'(irq_n), 8'h00);
        pa_in = 8'h50;
        nop();
        pa_in = 8'hD0;
        wr_reg(8'h05, 8'h80);
        rd_reg(8'h05);
        chk("edge_set_wins", d_out, 8'h80);
        wr_reg(8'h05, 8'h80);
        chk("edge_clr_irq", 8'(irq_n), 8'h01);

        // RAM, including the aliased address above RAM_AW.
        step(1, 1, 0, 0, 8'h7F, 8'h5C);
        step(1, 1, 1, 0, 8'h7F, 8'h00);
        chk("ram_rd", d_out, RAM_EN ? 8'h5C : 8'hFF);
        step(1, 1, 1, 0, 8'hFF, 8'h00);
        chk("ram_alias", d_out, RAM_EN ? 8'h5C : 8'hFF);

        for (int i = 0; i < (1 << AW); i++) step(1, 1, 0, 0, 8'(i), 8'($urandom));

        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            int sel;
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) pa_in = PW'($urandom);
            if ($urandom_range(0, 15) == 0) pb_in = PW'($urandom);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 8'($urandom_range(0, 7));
                1:       a = 8'($urandom_range(16, 31));
                2:       a = 8'($urandom);
                default: a = 8'h05;
            endcase
            step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0, a, 8'($urandom));
        end
        reset = 0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
